// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory-unit port among four requesters
`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 32
`endif
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 32
`endif

module mem_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = `MEMORY_ADDR_WIDTH,
  parameter int DATA_W  = `MEMORY_DATA_WIDTH,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_execute,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address1,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address2,
  input  logic [2*NUM_REQ-1:0]      req_func,
  input  logic [NUM_REQ*DATA_W-1:0] req_write_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      req_error,
  output logic [DATA_W-1:0]         req_read_data1,
  output logic [DATA_W-1:0]         req_read_data2,
  input  logic                      mem_ready,
  input  logic [DATA_W-1:0]         read_data1,
  input  logic [DATA_W-1:0]         read_data2,
  output logic                      mem_execute,
  output logic [ADDR_W-1:0]         address1,
  output logic [ADDR_W-1:0]         address2,
  output logic [1:0]                mem_func,
  output logic [DATA_W-1:0]         write_data,
  output logic [1:0]                grant_id,
  output logic                      busy,
  output logic                      timeout_flag
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RELEASE} state_t;

  state_t     state;
  logic [1:0] last;
  logic [7:0] cnt;
  logic [1:0] winner;
  logic [1:0] idx;
  logic       found;

  // Scan upward from the previous winner so it ends up with lowest priority.
  always_comb begin
    winner = last;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = last + 2'(i);
      if (!found && req_execute[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      last           <= 2'd3;
      cnt            <= '0;
      req_ready      <= '0;
      req_error      <= 1'b0;
      req_read_data1 <= '0;
      req_read_data2 <= '0;
      mem_execute    <= 1'b0;
      address1       <= '0;
      address2       <= '0;
      mem_func       <= '0;
      write_data     <= '0;
      grant_id       <= '0;
      busy           <= 1'b0;
      timeout_flag   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            address1    <= req_address1[winner*ADDR_W +: ADDR_W];
            address2    <= req_address2[winner*ADDR_W +: ADDR_W];
            mem_func    <= req_func[winner*2 +: 2];
            write_data  <= req_write_data[winner*DATA_W +: DATA_W];
            mem_execute <= 1'b1;
            grant_id    <= winner;
            last        <= winner;
            cnt         <= '0;
            busy        <= 1'b1;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          mem_execute <= 1'b0;
          if (mem_ready) begin
            req_read_data1 <= read_data1;
            req_read_data2 <= read_data2;
            req_ready      <= 4'b0001 << grant_id;
            state          <= S_RELEASE;
          end else if (cnt == 8'(TIMEOUT)) begin
            req_ready    <= 4'b0001 << grant_id;
            req_error    <= 1'b1;
            timeout_flag <= 1'b1;
            state        <= S_RELEASE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_RELEASE: begin
          req_ready <= '0;
          req_error <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] req_execute = '0;
  logic [AW-1:0] a1 [4];
  logic [AW-1:0] a2 [4];
  logic [DW-1:0] wd [4];
  logic [1:0] fn [4];
  logic [4*AW-1:0] req_address1, req_address2;
  logic [7:0] req_func;
  logic [4*DW-1:0] req_write_data;
  logic [3:0] req_ready;
  logic req_error;
  logic [DW-1:0] req_read_data1, req_read_data2;
  logic mem_ready = 1'b0;
  logic [DW-1:0] read_data1 = '0, read_data2 = '0;
  logic mem_execute;
  logic [AW-1:0] address1, address2;
  logic [1:0] mem_func;
  logic [DW-1:0] write_data;
  logic [1:0] grant_id;
  logic busy, timeout_flag;

  assign req_address1 = {a1[3], a1[2], a1[1], a1[0]};
  assign req_address2 = {a2[3], a2[2], a2[1], a2[0]};
  assign req_write_data = {wd[3], wd[2], wd[1], wd[0]};
  assign req_func = {fn[3], fn[2], fn[1], fn[0]};

  mem_arbiter #(.NUM_REQ(4), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_execute(req_execute),
    .req_address1(req_address1), .req_address2(req_address2),
    .req_func(req_func), .req_write_data(req_write_data),
    .req_ready(req_ready), .req_error(req_error),
    .req_read_data1(req_read_data1), .req_read_data2(req_read_data2),
    .mem_ready(mem_ready), .read_data1(read_data1), .read_data2(read_data2),
    .mem_execute(mem_execute), .address1(address1), .address2(address2),
    .mem_func(mem_func), .write_data(write_data), .grant_id(grant_id),
    .busy(busy), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] id; logic [AW-1:0] a1, a2; logic [DW-1:0] wd; logic [1:0] fn; } grant_t;
  typedef struct { logic [3:0] rdy; logic err; logic [DW-1:0] d1, d2; logic flag; } resp_t;

  grant_t grant_q[$];
  resp_t resp_q[$];
  int total = 0;
  int bad = 0;
  logic [DW-1:0] exp_rd1 = '0, exp_rd2 = '0;
  logic exp_flag = 1'b0;
  logic prev_exec = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (mem_execute) begin
        grant_t g;
        chk("exec_one_cycle", prev_exec, 0);
        if (grant_q.size() == 0) chk("unexpected_grant", 1, 0);
        else begin
          g = grant_q.pop_front();
          chk("grant_id", grant_id, g.id);
          chk("address1", address1, g.a1);
          chk("address2", address2, g.a2);
          chk("mem_func", mem_func, g.fn);
          chk("write_data", write_data, g.wd);
          chk("busy_in_wait", busy, 1);
        end
      end
      if (|req_ready) begin
        resp_t r;
        if (resp_q.size() == 0) chk("unexpected_ready", req_ready, 0);
        else begin
          r = resp_q.pop_front();
          chk("req_ready", req_ready, r.rdy);
          chk("req_error", req_error, r.err);
          chk("rd1", req_read_data1, r.d1);
          chk("rd2", req_read_data2, r.d2);
          chk("timeout_flag", timeout_flag, r.flag);
        end
      end
    end
    prev_exec = mem_execute;
  end

  task automatic do_reset();
    rst = 1'b0;
    mem_ready = 1'b0;
    req_execute = '0;
    exp_rd1 = '0; exp_rd2 = '0; exp_flag = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Expected winner is hand-chosen by the caller; lat is cycles from grant to req_ready.
  task automatic txn(input int who, input int lat, input logic [DW-1:0] d1,
                     input logic [DW-1:0] d2, input bit to);
    grant_t g; resp_t r; int n; bit seen;
    logic [AW-1:0] sa; logic [DW-1:0] sw;
    g.id = 2'(who); g.a1 = a1[who]; g.a2 = a2[who]; g.wd = wd[who]; g.fn = fn[who];
    grant_q.push_back(g);
    if (!to) begin exp_rd1 = d1; exp_rd2 = d2; end
    else exp_flag = 1'b1;
    r.rdy = 4'b0001 << who; r.err = to; r.d1 = exp_rd1; r.d2 = exp_rd2; r.flag = exp_flag;
    resp_q.push_back(r);
    seen = 0;
    for (n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = mem_execute;
    end
    chk("grant_seen", seen, 1);
    if (!seen) return;
    sa = a1[who]; sw = wd[who];
    a1[who] = ~sa; wd[who] = ~sw;
    if (to) begin read_data1 = 16'hDEAD; read_data2 = 16'hBEEF; end
    n = 0; seen = 0;
    while (!seen && n < 300) begin
      if (!to && n == lat - 1) begin
        mem_ready = 1'b1; read_data1 = d1; read_data2 = d2;
      end
      @(negedge clk);
      n++;
      mem_ready = 1'b0;
      seen = |req_ready;
    end
    chk("ready_latency", n, to ? TMO + 1 : lat);
    req_execute[who] = 1'b0;
    a1[who] = sa; wd[who] = sw;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      a1[i] = 16'h1000 + 16'(i * 16'h111);
      a2[i] = 16'h2000 + 16'(i * 16'h222);
      wd[i] = 16'h5A00 + 16'(i);
      fn[i] = 2'(3 - i);
    end
    repeat (2) @(negedge clk);
    chk("rst_mem_execute", mem_execute, 0);
    chk("rst_address1", address1, 0);
    chk("rst_address2", address2, 0);
    chk("rst_mem_func", mem_func, 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_req_error", req_error, 0);
    chk("rst_rd1", req_read_data1, 0);
    chk("rst_rd2", req_read_data2, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_flag", timeout_flag, 0);
    rst = 1'b1;
    @(negedge clk);

    a1[2] = 16'h0010; fn[2] = 2'd1;
    req_execute = 4'b0100;
    txn(2, 3, 16'h0ABC, 16'h0123, 0);
    chk("busy_idle", busy, 0);

    do_reset();
    req_execute = 4'b1111;
    txn(0, 1, 16'h1111, 16'h0001, 0);
    txn(1, 2, 16'h2222, 16'h0002, 0);
    txn(2, 3, 16'h3333, 16'h0003, 0);
    txn(3, 4, 16'h4444, 16'h0004, 0);
    req_execute = 4'b0011;
    txn(0, 2, 16'h5555, 16'h0005, 0);
    req_execute[0] = 1'b1;
    txn(1, 1, 16'h6666, 16'h0006, 0);
    txn(0, 3, 16'h7777, 16'h0007, 0);

    do_reset();
    req_execute = 4'b1010;
    txn(1, 2, 16'h8888, 16'h0008, 0);
    txn(3, 2, 16'h9999, 16'h0009, 0);

    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    mem_ready = 1'b0;
    chk("idle_ignores_mem_ready", busy, 0);

    req_execute = 4'b0001;
    txn(0, 0, '0, '0, 1);
    chk("flag_sticky", timeout_flag, 1);
    req_execute = 4'b0010;
    txn(1, TMO + 1, 16'hCAFE, 16'hF00D, 0);

    req_execute = 4'b0100;
    begin
      grant_t g; int n; bit seen;
      g.id = 2'd2; g.a1 = a1[2]; g.a2 = a2[2]; g.wd = wd[2]; g.fn = fn[2];
      grant_q.push_back(g);
      seen = 0;
      for (n = 0; n < 20 && !seen; n++) begin
        @(negedge clk);
        seen = mem_execute;
      end
      chk("midrst_grant_seen", seen, 1);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_grant_id", grant_id, 0);
    chk("midrst_address1", address1, 0);
    chk("midrst_write_data", write_data, 0);
    chk("midrst_rd1", req_read_data1, 0);
    chk("midrst_timeout_flag", timeout_flag, 0);
    exp_rd1 = '0; exp_rd2 = '0; exp_flag = 1'b0;
    mem_ready = 1'b1;
    req_execute = 4'b0011;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_ready", req_ready, 0);
    end
    mem_ready = 1'b0;
    rst = 1'b1;
    txn(0, 2, 16'h0A0A, 16'h0B0B, 0);
    txn(1, 1, 16'h0C0C, 16'h0D0D, 0);

    repeat (3) @(negedge clk);
    chk("grant_q_empty", grant_q.size(), 0);
    chk("resp_q_empty", resp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter sharing the single memory-unit port between four requesters: traversal, execute, cell and one spare. Each requester presents the same request bundle a unit drives to memory today: execute, two addresses, func and write data. The arbiter grants one requester at a time and forwards that request to the memory unit. It holds the grant until `mem_ready` arrives or a watchdog expires, then returns latched read data and a one-cycle ready pulse to the winner.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters. Fixed at 4; index width 2.
- `ADDR_W`, `` `memory_addr_width ``: address width.
- `DATA_W`, `` `memory_data_width ``: data width.
- `TIMEOUT`, 255: cycles in WAIT without `mem_ready` before abort. Range 1..255.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `req_execute` in 4: per-requester request. Held high until that requester's `req_ready` is seen.
- `req_address1` in 4*ADDR_W: packed; requester i occupies bits [i*ADDR_W +: ADDR_W].
- `req_address2` in 4*ADDR_W: packed, same layout.
- `req_func` in 8: packed, 2 bits per requester.
- `req_write_data` in 4*DATA_W: packed.
- `req_ready` out 4: one-hot, one-cycle completion pulse.
- `req_error` out 1: high together with `req_ready` when the transaction timed out.
- `req_read_data1`, `req_read_data2` out DATA_W: latched memory read data, broadcast to all requesters.
- `mem_ready` in 1: memory-unit completion.
- `read_data1`, `read_data2` in DATA_W: memory-unit read data.
- `mem_execute` out 1, `address1` out ADDR_W, `address2` out ADDR_W, `mem_func` out 2, `write_data` out DATA_W: memory-unit request.
- `grant_id` out 2: index of the current or most recent grantee.
- `busy` out 1: high in WAIT and RELEASE.
- `timeout_flag` out 1: sticky. Set by any timeout, cleared only by reset.

## Operation
- All outputs are registered.
- States: IDLE, WAIT, RELEASE.
- **IDLE**
  - If `req_execute` is nonzero, choose the first set bit scanning from (last+1) mod 4 upward with wrap-around.
  - Latch that requester's address1, address2, func and write_data onto the memory outputs.
  - Set `mem_execute`=1, `grant_id`=winner, last=winner, clear the watchdog counter, go to WAIT.
  - If `req_execute` is zero, stay in IDLE.
- **WAIT**
  - `mem_execute` is forced to 0 every WAIT cycle, so it is high for exactly one cycle per grant.
  - Memory outputs other than `mem_execute` hold their values.
  - If `mem_ready`=1: latch `read_data1` and `read_data2` into `req_read_data1` and `req_read_data2`, set `req_ready[grant_id]`=1, go to RELEASE.
  - Else if counter==TIMEOUT: set `req_ready[grant_id]`=1, `req_error`=1, `timeout_flag`=1. Read data is unchanged. Go to RELEASE.
  - Otherwise increment the counter (8 bit, no wrap because TIMEOUT ≤ 255).
  - If `mem_ready` and timeout occur in the same cycle, `mem_ready` wins and no error is raised.
- **RELEASE**
  - Clear `req_ready` and `req_error`, go to IDLE.
  - `req_execute` is not sampled in this state. The grantee must drop its request on the edge where it sees `req_ready`.
- The previous winner has lowest priority next round. A requester that keeps asserting therefore cannot starve the others.
- `busy` = (state != IDLE).
- Changes on a requester's bundle after grant are ignored; the bundle is captured only in IDLE.

## Timing
- Reset (asynchronous, immediate, also mid-transaction):
  - state=IDLE, last=3 so requester 0 has first priority, counter=0.
  - All outputs 0: `mem_execute`, addresses, `mem_func`, `write_data`, `req_ready`, `req_error`, read-data latches, `grant_id`, `busy`, `timeout_flag`.
  - A transaction in flight is abandoned and no `req_ready` is issued.
- Request sampled at edge E0 → `mem_execute` high in the cycle after E0 and low after E0+1.
- `mem_ready` sampled at edge Ek in WAIT (k≥1) → `req_ready` and data valid for the cycle after Ek → next grant decided at Ek+2 → next `mem_execute` high after Ek+2.
- Minimum occupancy is 3 cycles per grant (IDLE, WAIT, RELEASE).
- Timeout: `req_ready` and `req_error` pulse after WAIT has run TIMEOUT+1 cycles without `mem_ready`.
- `mem_ready` arriving while in IDLE or RELEASE is ignored.

## Test plan
- Single request: after reset, requester 2 asserts with addr1=0x10, func=1. Expect `mem_execute` high for exactly 1 cycle with `address1`=0x10, `mem_func`=1, `grant_id`=2. Memory returns ready 3 cycles later with `read_data1`=0xABC. Expect `req_ready`=4'b0100 for 1 cycle and `req_read_data1`=0xABC.
- Fairness: all 4 requesters assert continuously and drop only on their own ready. Expect grant order 0,1,2,3. Re-asserting 0 and 1 afterwards grants 0 then 1; no requester is granted twice consecutively while another is waiting.
- Wrap-around: last=3, requesters 1 and 3 assert. Expect requester 1 granted first, then 3.
- Timeout: TIMEOUT=4, `mem_ready` never asserts. Expect `req_ready` plus `req_error` exactly 5 WAIT cycles after grant, `timeout_flag` set and staying set, read-data latches unchanged.
- Simultaneous: `mem_ready` arrives on the cycle the counter reaches TIMEOUT. Expect `req_error`=0, data latched, `timeout_flag` unchanged.
- Reset mid-operation: assert `rst` low during WAIT. Expect all outputs 0 immediately and no `req_ready`. After release, requester 0 has priority over requester 1.
